game_ctrl: RTL and testbench



---
 rtl/game_ctrl.sv | 102 ++++++++++
 tb/tb_game_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: round flow, collision detection and BCD scoring for the flappy game
module game_ctrl #(
  parameter logic [7:0] FLAP_KEY       = 8'h44,
  parameter int         Y_MIN          = 0,
  parameter int         GROUND_Y       = 479,
  parameter int         PIPE_HALF_W    = 16,
  parameter int         GAP_HALF       = 48,
  parameter int         DEATH_FRAMES   = 60,
  parameter int         LOCKOUT_FRAMES = 30
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] BirdX,
  input  logic [9:0] BirdY,
  input  logic [9:0] BirdS,
  input  logic [9:0] PipeX,
  input  logic [9:0] GapY,
  output logic       bird_reset,
  output logic       pipes_run,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic [7:0] hi_score
);
  typedef enum logic [1:0] {READY, PLAYING, DYING, GAME_OVER} st_t;
  localparam logic [10:0] YM = 11'(Y_MIN);
  localparam logic [10:0] GND = 11'(GROUND_Y);
  localparam logic [10:0] PH = 11'(PIPE_HALF_W);
  localparam logic [10:0] GH = 11'(GAP_HALF);
  localparam logic [7:0] DIE_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] LOCK = 8'(LOCKOUT_FRAMES);
  st_t st;
  logic [7:0] key_prev, counter, score_inc;
  logic [9:0] pipe_prev;
  logic scored, flap, hit, pass, hx, vy;
  logic [10:0] bx, by, bs, px, gy;
  assign state = st;
  // widen to 11 bits so every sum fits without wrap; no subtraction anywhere
  always_comb begin
    bx = {1'b0, BirdX};
    by = {1'b0, BirdY};
    bs = {1'b0, BirdS};
    px = {1'b0, PipeX};
    gy = {1'b0, GapY};
    flap = (keycode == FLAP_KEY) && (key_prev != FLAP_KEY);
    hx = (bx + bs + PH > px) && (px + bs + PH > bx);
    vy = (by + GH < gy + bs) || (by + bs > gy + GH);
    hit = (by <= YM + bs) || (by + bs >= GND) || (hx && vy);
    pass = px + PH + bs < bx;
    score_inc = (score == 8'h99) ? score :
                (score[3:0] == 4'h9) ? {score[7:4] + 4'h1, 4'h0} : score + 8'h1;
  end
  // round state machine with registered control outputs and score bookkeeping
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st <= READY;
      bird_reset <= 1'b1;
      pipes_run <= 1'b0;
      score <= 8'h00;
      hi_score <= 8'h00;
      key_prev <= 8'h00;
      scored <= 1'b0;
      pipe_prev <= 10'd0;
      counter <= 8'd0;
    end else begin
      key_prev <= keycode;
      pipe_prev <= PipeX;
      case (st)
        READY: if (flap) begin
          st <= PLAYING;
          bird_reset <= 1'b0;
          pipes_run <= 1'b1;
          score <= 8'h00;
          scored <= 1'b0;
        end
        PLAYING: if (hit) begin
          st <= DYING;
          pipes_run <= 1'b0;
          counter <= 8'd0;
          hi_score <= (score > hi_score) ? score : hi_score;
        end else if (!scored && pass) begin
          score <= score_inc;
          scored <= 1'b1;
        end else if (PipeX > pipe_prev) begin
          scored <= 1'b0;
        end
        DYING: if (counter == DIE_LAST) begin
          st <= GAME_OVER;
          bird_reset <= 1'b1;
          counter <= 8'd0;
        end else begin
          counter <= counter + 8'd1;
        end
        GAME_OVER: begin
          counter <= (counter == LOCK) ? counter : counter + 8'd1;
          if (flap && counter == LOCK) st <= READY;
        end
        default: st <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed stimulus with a frame-level reference model of game_ctrl
module tb_game_ctrl;
  logic Reset = 1'b0, frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] BirdX = 10'd160, BirdY = 10'd240, BirdS = 10'd4, PipeX = 10'd300, GapY = 10'd240;
  logic bird_reset, pipes_run;
  logic [1:0] state;
  logic [7:0] score, hi_score;
  int n_pass = 0, n_tot = 0;
  int m_st, m_sc, m_hi, m_fr, m_pp, bx, by, bs, px, gy;
  bit m_scored, flap, hit, pass;
  logic [7:0] m_key;

  game_ctrl dut (.Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .BirdX(BirdX),
    .BirdY(BirdY), .BirdS(BirdS), .PipeX(PipeX), .GapY(GapY), .bird_reset(bird_reset),
    .pipes_run(pipes_run), .state(state), .score(score), .hi_score(hi_score));

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  // reference model: decimal score, frames-in-state timer, geometry with signed ints
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_sc = 0; m_hi = 0; m_fr = 0; m_pp = 0; m_scored = 0; m_key = 8'h00;
    end else begin
      bx = BirdX; by = BirdY; bs = BirdS; px = PipeX; gy = GapY;
      flap = (keycode == 8'h44) && (m_key != 8'h44);
      hit = (by - bs <= 0) || (by + bs >= 479) ||
            (((bx > px ? bx - px : px - bx) < bs + 16) && ((by - bs < gy - 48) || (by + bs > gy + 48)));
      pass = bx - px > bs + 16;
      m_fr++;
      case (m_st)
        0: if (flap) begin m_st = 1; m_sc = 0; m_scored = 0; end
        1: if (hit) begin
             m_st = 2; m_fr = 0;
             if (m_sc > m_hi) m_hi = m_sc;
           end else if (!m_scored && pass) begin
             m_sc = (m_sc < 99) ? m_sc + 1 : 99; m_scored = 1;
           end else if (px > m_pp) m_scored = 0;
        2: if (m_fr >= 60) begin m_st = 3; m_fr = 0; end
        default: if (flap && m_fr > 30) m_st = 0;
      endcase
      m_key = keycode;
      m_pp = px;
    end
  end

  // every-frame comparison against the model, away from the active edge
  always @(negedge frame_clk) begin
    chk("state", state, m_st);
    chk("bird_reset", bird_reset, (m_st == 0 || m_st == 3) ? 1 : 0);
    chk("pipes_run", pipes_run, (m_st == 1) ? 1 : 0);
    chk("score", score, to_bcd(m_sc));
    chk("hi_score", hi_score, to_bcd(m_hi));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic pass_pipe();
    PipeX = 10'd300; tick(1);
    PipeX = 10'd100; tick(1);
  endtask

  task automatic to_ready();
    keycode = 8'h00; tick(95);
    keycode = 8'h44; tick(1);
    keycode = 8'h00; tick(1);
    chk("lit_ready", state, 0);
  endtask

  task automatic start_round();
    BirdY = 10'd240; PipeX = 10'd300; GapY = 10'd240;
    keycode = 8'h44; tick(1);
    keycode = 8'h00;
    chk("lit_start_state", state, 1);
    chk("lit_start_score", score, 8'h00);
  endtask

  initial begin
    #1 Reset = 1'b1;
    #2;
    chk("lit_rst_state", state, 0);
    chk("lit_rst_bird_reset", bird_reset, 1);
    chk("lit_rst_pipes_run", pipes_run, 0);
    chk("lit_rst_score", score, 8'h00);
    chk("lit_rst_hi", hi_score, 8'h00);
    @(negedge frame_clk) Reset = 1'b0;
    tick(2);
    keycode = 8'h44; tick(1);
    chk("lit_flap_state", state, 1);
    chk("lit_flap_bird_reset", bird_reset, 0);
    chk("lit_flap_pipes_run", pipes_run, 1);
    tick(4);
    chk("lit_held_state", state, 1);
    keycode = 8'h00;
    for (int p = 300; p >= 140; p -= 20) begin PipeX = 10'(p); tick(1); end
    chk("lit_before_pass", score, 8'h00);
    PipeX = 10'd120; tick(1);
    chk("lit_first_pass", score, 8'h01);
    PipeX = 10'd100; tick(3);
    chk("lit_hold_low", score, 8'h01);
    for (int p = 640; p >= 100; p -= 20) begin PipeX = 10'(p); tick(1); end
    chk("lit_second_pass", score, 8'h02);
    PipeX = 10'd160; GapY = 10'd100; tick(1);
    chk("lit_dying", state, 2);
    chk("lit_hi_after_death", hi_score, 8'h02);
    tick(58);
    keycode = 8'h44; tick(1);
    chk("lit_dying_last", state, 2);
    tick(1);
    chk("lit_game_over", state, 3);
    keycode = 8'h00; tick(9);
    keycode = 8'h44; tick(1);
    chk("lit_lockout_10", state, 3);
    keycode = 8'h00; tick(19);
    keycode = 8'h44; tick(1);
    chk("lit_lockout_30", state, 3);
    keycode = 8'h00; tick(1);
    keycode = 8'h44; tick(1);
    chk("lit_restart", state, 0);
    chk("lit_restart_bird_reset", bird_reset, 1);
    keycode = 8'h00; tick(1);
    start_round();
    repeat (98) pass_pipe();
    chk("lit_score_98", score, 8'h98);
    pass_pipe();
    chk("lit_score_99", score, 8'h99);
    pass_pipe();
    chk("lit_score_sat", score, 8'h99);
    PipeX = 10'd300; tick(1);
    PipeX = 10'd100; BirdY = 10'd475; tick(1);
    chk("lit_ground_state", state, 2);
    chk("lit_hi_99", hi_score, 8'h99);
    BirdY = 10'd240;
    to_ready();
    start_round();
    repeat (4) pass_pipe();
    PipeX = 10'd300; tick(1);
    PipeX = 10'd100; BirdY = 10'd475; tick(1);
    chk("lit_collide_wins_state", state, 2);
    chk("lit_collide_wins_score", score, 8'h04);
    chk("lit_collide_keeps_hi", hi_score, 8'h99);
    BirdY = 10'd240;
    to_ready();
    start_round();
    repeat (5) pass_pipe();
    chk("lit_score_05", score, 8'h05);
    @(posedge frame_clk);
    #3 Reset = 1'b1;
    #1;
    chk("lit_async_state", state, 0);
    chk("lit_async_score", score, 8'h00);
    chk("lit_async_hi", hi_score, 8'h00);
    chk("lit_async_bird_reset", bird_reset, 1);
    chk("lit_async_pipes_run", pipes_run, 0);
    @(negedge frame_clk) Reset = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
